// File: rtl/pixel_data_parser.sv
// pixel_data_parser: hunts SOF, validates repeated headers, reassembles DLEN payload bytes, checks EOF.
// Rev 1.0
`default_nettype none

module pixel_data_parser #(
  parameter int unsigned DLEN       = 32'h002b,
  parameter logic [7:0]  PHL_ID     = 8'h00,
  parameter int unsigned HDR_REPEAT = 2
) (
  input  logic              rx_pixel_clk,
  input  logic              rst_n,
  input  logic [63:0]       pixel_value,
  input  logic              pixel_valid,
  output logic [DLEN*8-1:0] data,
  output logic [7:0]        dtype,
  output logic              data_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned R          = DLEN % 6;
  localparam int unsigned CW         = $clog2(DLEN + 6);
  localparam bit          NEEDS_EOF2 = (R == 0) || (R == 5);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_EOF2 = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state;
  logic [47:0]     hdr_first;
  logic [1:0]      hdr_cnt;
  logic [CW-1:0]   byte_cnt;

  logic [47:0]     w;
  logic [31:0]     len_field;
  logic            bad_copy;
  logic            last_word;
  logic            eof_in_last;
  logic            eof2_ok;
  logic            unused_hi;

  assign w         = pixel_value[47:0];
  assign unused_hi = ^pixel_value[63:48];
  assign len_field = {w[15:8], w[23:16], w[31:24], w[39:32]};
  assign bad_copy  = (w[47:40] != PHL_ID) || ((hdr_cnt != 2'd0) && (w != hdr_first));
  assign last_word = (32'(byte_cnt) + 32'd6) >= DLEN;

  // Where the AA/DD marker bytes land depends only on DLEN mod 6.
  generate
    if (R == 0) begin : g_eof_r0
      assign eof_in_last = 1'b1;
      assign eof2_ok     = (w[15:0] == 16'hDDAA);
    end else if (R == 5) begin : g_eof_r5
      assign eof_in_last = (w[47:40] == 8'hAA);
      assign eof2_ok     = (w[7:0] == 8'hDD);
    end else begin : g_eof_rn
      assign eof_in_last = (w[R*8 +: 8] == 8'hAA) && (w[(R+1)*8 +: 8] == 8'hDD);
      assign eof2_ok     = 1'b1;
    end
  endgenerate

  always_ff @(posedge rx_pixel_clk) begin
    if (!rst_n) begin
      state      <= S_HUNT;
      hdr_first  <= '0;
      hdr_cnt    <= '0;
      byte_cnt   <= '0;
      data       <= '0;
      dtype      <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      data_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_HUNT: begin
          if (pixel_valid && (w[15:0] == 16'hFFEA)) begin
            state   <= S_HDR;
            busy    <= 1'b1;
            hdr_cnt <= '0;
          end
        end
        S_HDR: begin
          if (pixel_valid) begin
            if (hdr_cnt == 2'd0) hdr_first <= w;
            if (bad_copy) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= 2'd1;
              busy     <= 1'b0;
            end else if (len_field != DLEN) begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= 2'd2;
              busy     <= 1'b0;
            end else if (32'(hdr_cnt) == HDR_REPEAT - 1) begin
              state    <= S_PAY;
              byte_cnt <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + 2'd1;
            end
          end
        end
        S_PAY: begin
          if (pixel_valid) begin
            // Lanes that would fall beyond the payload are dropped, never indexed.
            for (int k = 0; k < 6; k++) begin
              if (32'(byte_cnt) + 32'(k) < DLEN)
                data[(32'(byte_cnt) + 32'(k))*8 +: 8] <= w[k*8 +: 8];
            end
            byte_cnt <= byte_cnt + CW'(6);
            if (last_word) begin
              if (!eof_in_last) begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= 2'd3;
                busy     <= 1'b0;
              end else if (NEEDS_EOF2) begin
                state <= S_EOF2;
              end else begin
                state      <= S_DONE;
                data_valid <= 1'b1;
                dtype      <= hdr_first[7:0];
                busy       <= 1'b0;
              end
            end
          end
        end
        S_EOF2: begin
          if (pixel_valid) begin
            if (eof2_ok) begin
              state      <= S_DONE;
              data_valid <= 1'b1;
              dtype      <= hdr_first[7:0];
              busy       <= 1'b0;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= 2'd3;
              busy     <= 1'b0;
            end
          end
        end
        S_DONE:  state <= S_HUNT;
        S_ERR:   state <= S_HUNT;
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_data_parser.sv
// tb_pixel_data_parser: directed frames against DLEN=43, 42 and 41 builds of pixel_data_parser.
`default_nettype none

module tb_pixel_data_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pval [3];
  logic        pvld [3];
  logic [343:0] d43;
  logic [335:0] d42;
  logic [327:0] d41;
  logic [7:0]  dt  [3];
  logic        dv  [3];
  logic        bsy [3];
  logic        er  [3];
  logic [1:0]  ec  [3];

  int n_cmp = 0;
  int n_bad = 0;
  int dv_cnt [3] = '{0, 0, 0};
  int err_cnt[3] = '{0, 0, 0};
  int exp_dv = 0;
  int exp_err = 0;
  logic [47:0] frm[$];

  always #5 clk = ~clk;

  pixel_data_parser #(.DLEN(43), .PHL_ID(8'h00), .HDR_REPEAT(2)) u_dut43 (
    .rx_pixel_clk(clk), .rst_n(rst_n), .pixel_value(pval[0]), .pixel_valid(pvld[0]),
    .data(d43), .dtype(dt[0]), .data_valid(dv[0]), .busy(bsy[0]), .err(er[0]), .err_code(ec[0]));

  pixel_data_parser #(.DLEN(42), .PHL_ID(8'h00), .HDR_REPEAT(2)) u_dut42 (
    .rx_pixel_clk(clk), .rst_n(rst_n), .pixel_value(pval[1]), .pixel_valid(pvld[1]),
    .data(d42), .dtype(dt[1]), .data_valid(dv[1]), .busy(bsy[1]), .err(er[1]), .err_code(ec[1]));

  pixel_data_parser #(.DLEN(41), .PHL_ID(8'h00), .HDR_REPEAT(2)) u_dut41 (
    .rx_pixel_clk(clk), .rst_n(rst_n), .pixel_value(pval[2]), .pixel_valid(pvld[2]),
    .data(d41), .dtype(dt[2]), .data_valid(dv[2]), .busy(bsy[2]), .err(er[2]), .err_code(ec[2]));

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (dv[s]) dv_cnt[s]++;
      if (er[s]) err_cnt[s]++;
    end
  end

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] dget(input int s);
    case (s)
      0:       return 384'(d43);
      1:       return 384'(d42);
      default: return 384'(d41);
    endcase
  endfunction

  function automatic logic [383:0] exp_data(input int dlen, input logic [7:0] base);
    logic [383:0] r = '0;
    for (int i = 0; i < dlen; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  // Builds SOF, two header copies, payload base..base+dlen-1 followed by the two EOF bytes.
  task automatic build(input int dlen, input logic [7:0] dt1, input logic [7:0] dt2,
                       input logic [31:0] len, input logic [7:0] aa, input logic [7:0] dd,
                       input logic [7:0] base);
    logic [7:0]  bytes[$];
    logic [47:0] wd;
    frm = {};
    frm.push_back(48'h0000_0000_FFEA);
    frm.push_back({8'h00, len[7:0], len[15:8], len[23:16], len[31:24], dt1});
    frm.push_back({8'h00, len[7:0], len[15:8], len[23:16], len[31:24], dt2});
    for (int i = 0; i < dlen; i++) bytes.push_back(base + 8'(i));
    bytes.push_back(aa);
    bytes.push_back(dd);
    for (int i = 0; i < bytes.size(); i += 6) begin
      wd = '0;
      for (int k = 0; k < 6; k++) if (i + k < bytes.size()) wd[k*8 +: 8] = bytes[i+k];
      frm.push_back(wd);
    end
  endtask

  task automatic play(input int sel, input int gap, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      @(negedge clk);
      pval[sel] = {16'hBEEF, frm[i]};
      pvld[sel] = 1'b1;
      if (i < nwords - 1) repeat (gap) begin
        @(negedge clk);
        pvld[sel] = 1'b0;
      end
    end
    @(negedge clk);
    pvld[sel] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [383:0] e;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pval[s] = '0;
      pvld[s] = 1'b0;
    end
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_eq("rst_data",  dget(0), '0);
    check_eq("rst_dv",    384'(dv[0]), '0);
    check_eq("rst_busy",  384'(bsy[0]), '0);
    check_eq("rst_err",   384'(er[0]), '0);
    check_eq("rst_ecode", 384'(ec[0]), '0);
    check_eq("rst_dtype", 384'(dt[0]), '0);

    // Nominal frame, back-to-back words
    build(43, 8'h05, 8'h05, 32'd43, 8'hAA, 8'hDD, 8'h00);
    check_eq("t1_lastword", 384'(frm[10]), 384'(48'h0000_00DD_AA2A));
    play(0, 0, frm.size());
    exp_dv++;
    check_eq("t1_dv_latency", 384'(dv[0]), 384'(1'b1));
    check_eq("t1_data",   dget(0), exp_data(43, 8'h00));
    check_eq("t1_byte0",  384'(d43[7:0]), 384'(8'h00));
    check_eq("t1_byte42", 384'(d43[343:336]), 384'(8'h2A));
    check_eq("t1_dtype",  384'(dt[0]), 384'(8'h05));
    check_eq("t1_busy",   384'(bsy[0]), '0);
    idle(1);
    check_eq("t1_dv_pulse", 384'(dv[0]), '0);

    // pixel_valid toggling every cycle
    build(43, 8'h06, 8'h06, 32'd43, 8'hAA, 8'hDD, 8'h10);
    play(0, 1, frm.size());
    exp_dv++;
    check_eq("t2_dv",    384'(dv[0]), 384'(1'b1));
    check_eq("t2_data",  dget(0), exp_data(43, 8'h10));
    check_eq("t2_dtype", 384'(dt[0]), 384'(8'h06));
    idle(2);
    check_eq("t2_errcnt", 384'(err_cnt[0]), 384'(exp_err));

    // Wrong length field, then a good frame
    build(43, 8'h07, 8'h07, 32'h2C, 8'hAA, 8'hDD, 8'h00);
    play(0, 0, frm.size());
    exp_err++;
    idle(2);
    check_eq("t3_errcnt", 384'(err_cnt[0]), 384'(exp_err));
    check_eq("t3_ecode",  384'(ec[0]), 384'(2'd2));
    check_eq("t3_busy",   384'(bsy[0]), '0);
    check_eq("t3_dvcnt",  384'(dv_cnt[0]), 384'(exp_dv));
    build(43, 8'h08, 8'h08, 32'd43, 8'hAA, 8'hDD, 8'h20);
    play(0, 0, frm.size());
    exp_dv++;
    check_eq("t3_recover_dv",   384'(dv[0]), 384'(1'b1));
    check_eq("t3_recover_data", dget(0), exp_data(43, 8'h20));

    // Header copies disagree on DTYPE
    build(43, 8'h01, 8'h02, 32'd43, 8'hAA, 8'hDD, 8'h00);
    play(0, 0, frm.size());
    exp_err++;
    idle(2);
    check_eq("t4_errcnt", 384'(err_cnt[0]), 384'(exp_err));
    check_eq("t4_ecode",  384'(ec[0]), 384'(2'd1));

    // Bad EOF marker
    build(43, 8'h09, 8'h09, 32'd43, 8'hAA, 8'hDC, 8'h00);
    play(0, 0, frm.size());
    exp_err++;
    idle(2);
    check_eq("t5_errcnt", 384'(err_cnt[0]), 384'(exp_err));
    check_eq("t5_ecode",  384'(ec[0]), 384'(2'd3));
    check_eq("t5_dvcnt",  384'(dv_cnt[0]), 384'(exp_dv));

    // SOF pattern inside payload is just data
    build(43, 8'h0A, 8'h0A, 32'd43, 8'hAA, 8'hDD, 8'h30);
    frm[3][15:0] = 16'hFFEA;
    e = exp_data(43, 8'h30);
    e[15:0] = 16'hFFEA;
    play(0, 0, frm.size());
    exp_dv++;
    check_eq("t6_dv",   384'(dv[0]), 384'(1'b1));
    check_eq("t6_data", dget(0), e);
    idle(2);
    check_eq("t6_errcnt", 384'(err_cnt[0]), 384'(exp_err));

    // Reset in the middle of a payload
    build(43, 8'h0B, 8'h0B, 32'd43, 8'hAA, 8'hDD, 8'h40);
    play(0, 0, 6);
    check_eq("t7_busy_mid", 384'(bsy[0]), 384'(1'b1));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_eq("t7_data",  dget(0), '0);
    check_eq("t7_busy",  384'(bsy[0]), '0);
    check_eq("t7_ecode", 384'(ec[0]), '0);
    check_eq("t7_dtype", 384'(dt[0]), '0);
    build(43, 8'h0C, 8'h0C, 32'd43, 8'hAA, 8'hDD, 8'h50);
    play(0, 0, frm.size());
    check_eq("t7_after_dv",   384'(dv[0]), 384'(1'b1));
    check_eq("t7_after_data", dget(0), exp_data(43, 8'h50));

    // DLEN=42: separate DDAA word
    build(42, 8'h42, 8'h42, 32'd42, 8'hAA, 8'hDD, 8'h60);
    check_eq("t8_eofword", 384'(frm[frm.size()-1]), 384'(48'h0000_0000_DDAA));
    play(1, 0, frm.size());
    check_eq("t8_dv",    384'(dv[1]), 384'(1'b1));
    check_eq("t8_data",  dget(1), exp_data(42, 8'h60));
    check_eq("t8_dtype", 384'(dt[1]), 384'(8'h42));

    // DLEN=41: AA in lane 5, DD in next word lane 0
    build(41, 8'h41, 8'h41, 32'd41, 8'hAA, 8'hDD, 8'h70);
    play(2, 0, frm.size());
    check_eq("t9_dv",    384'(dv[2]), 384'(1'b1));
    check_eq("t9_data",  dget(2), exp_data(41, 8'h70));
    check_eq("t9_dtype", 384'(dt[2]), 384'(8'h41));
    idle(2);
    check_eq("t9_errcnt", 384'(err_cnt[1] + err_cnt[2]), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
